// File: rtl/s3g_tx_if.sv
// Host-side and UART-side signal bundle for the S3G packet framer.
// The master modport is the environment (host plus UART); the slave is the framer.
interface s3g_tx_if #(
    parameter int ADDR_W = 5
) ();
    logic              buf_wr;
    logic [ADDR_W-1:0] buf_addr;
    logic [7:0]        buf_data;
    logic              send;
    logic [7:0]        send_len;
    logic              busy;
    logic              done;
    logic              err;
    logic [7:0]        tx_data;
    logic              tx_wr;
    logic              tx_done;

    modport master (
        output buf_wr, buf_addr, buf_data, send, send_len, tx_done,
        input  busy, done, err, tx_data, tx_wr
    );

    modport slave (
        input  buf_wr, buf_addr, buf_data, send, send_len, tx_done,
        output busy, done, err, tx_data, tx_wr
    );
endinterface

// File: rtl/s3g_tx.sv
// S3G transmit framer: buffers one payload and emits it to the UART as
// 0xD5, length, payload bytes, CRC-8 (Maxim, reflected 0x8C, payload only).
// Each byte is strobed once and the next one waits for the UART's tx_done.
module s3g_tx #(
    parameter int MAX_LEN = 32,
    parameter int ADDR_W  = $clog2(MAX_LEN)
) (
    input logic     clk,
    input logic     rst,
    s3g_tx_if.slave bus
);

    localparam logic [7:0] SOF       = 8'hD5;
    localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

    typedef enum logic [2:0] {IDLE, HDR, LEN, DATA, CRC} state_t;

    state_t      state_q, state_n;
    logic        issued_q, issued_n;   // current state's byte has been strobed
    logic        seen_q, seen_n;       // registered tx_done for the issued byte
    logic [7:0]  len_q, len_n;
    logic [7:0]  idx_q, idx_n;         // payload bytes already issued
    logic [7:0]  crc_q, crc_n;
    logic [7:0]  tx_data_q, tx_data_n;
    logic        tx_wr_q, tx_wr_n;
    logic        busy_q, busy_n;
    logic        done_q, done_n;
    logic        err_q, err_n;
    logic        issue_data;

    logic [7:0]  mem [MAX_LEN];
    logic [7:0]  rd_data_q;

    // One byte of Maxim CRC-8, LSB first with the reflected polynomial.
    function automatic logic [7:0] crc8_byte(input logic [7:0] crc_in, input logic [7:0] b);
        logic [7:0] c;
        c = crc_in ^ b;
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ 8'h8C) : (c >> 1);
        end
        return c;
    endfunction

    // Payload buffer: writes locked out while a packet is in flight; the
    // registered read always tracks the next payload byte to be sent.
    always_ff @(posedge clk) begin
        if (bus.buf_wr && !busy_q) begin
            mem[bus.buf_addr] <= bus.buf_data;
        end
        rd_data_q <= mem[idx_q[ADDR_W-1:0]];
    end

    // State and control registers; reset returns to IDLE at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            issued_q  <= 1'b0;
            seen_q    <= 1'b0;
            len_q     <= 8'h00;
            idx_q     <= 8'h00;
            crc_q     <= 8'h00;
            tx_data_q <= 8'h00;
            tx_wr_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_n;
            issued_q  <= issued_n;
            seen_q    <= seen_n;
            len_q     <= len_n;
            idx_q     <= idx_n;
            crc_q     <= crc_n;
            tx_data_q <= tx_data_n;
            tx_wr_q   <= tx_wr_n;
            busy_q    <= busy_n;
            done_q    <= done_n;
            err_q     <= err_n;
        end
    end

    // Next-state logic: a byte is issued on entry to HDR, and thereafter on
    // the edge after tx_done is seen, together with the state advance.
    always_comb begin
        state_n    = state_q;
        issued_n   = issued_q;
        len_n      = len_q;
        idx_n      = idx_q;
        crc_n      = crc_q;
        tx_data_n  = tx_data_q;
        tx_wr_n    = 1'b0;
        busy_n     = busy_q;
        done_n     = 1'b0;
        err_n      = 1'b0;
        issue_data = 1'b0;
        // A second tx_done in the advancing cycle must not count for the new byte.
        seen_n     = bus.tx_done && issued_q && !seen_q && (state_q != IDLE);

        case (state_q)
            IDLE: begin
                if (bus.send) begin
                    if (bus.send_len > MAX_LEN_B) begin
                        err_n = 1'b1;
                    end else begin
                        state_n  = HDR;
                        len_n    = bus.send_len;
                        crc_n    = 8'h00;
                        idx_n    = 8'h00;
                        issued_n = 1'b0;
                    end
                end
            end
            HDR: begin
                if (!issued_q) begin
                    tx_wr_n   = 1'b1;
                    tx_data_n = SOF;
                    issued_n  = 1'b1;
                    busy_n    = 1'b1;
                end else if (seen_q) begin
                    state_n   = LEN;
                    tx_wr_n   = 1'b1;
                    tx_data_n = len_q;
                end
            end
            LEN: begin
                if (seen_q) begin
                    if (len_q == 8'h00) begin
                        state_n   = CRC;
                        tx_wr_n   = 1'b1;
                        tx_data_n = crc_q;
                    end else begin
                        state_n    = DATA;
                        issue_data = 1'b1;
                    end
                end
            end
            DATA: begin
                if (seen_q) begin
                    if (idx_q == len_q) begin
                        state_n   = CRC;
                        tx_wr_n   = 1'b1;
                        tx_data_n = crc_q;
                    end else begin
                        issue_data = 1'b1;
                    end
                end
            end
            CRC: begin
                if (seen_q) begin
                    state_n  = IDLE;
                    issued_n = 1'b0;
                    busy_n   = 1'b0;
                    done_n   = 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        if (issue_data) begin
            tx_wr_n   = 1'b1;
            tx_data_n = rd_data_q;
            crc_n     = crc8_byte(crc_q, rd_data_q);
            idx_n     = idx_q + 8'd1;
        end
    end

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.err     = err_q;
    assign bus.tx_data = tx_data_q;
    assign bus.tx_wr   = tx_wr_q;

endmodule

// File: tb/tb_s3g_tx.sv
// Directed bench for the S3G transmit framer with a cycle-stepped UART stand-in.
module tb_s3g_tx;

    logic clk;
    logic rst;

    s3g_tx_if #(.ADDR_W(5)) bus ();

    s3g_tx #(.MAX_LEN(32)) dut (.clk(clk), .rst(rst), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [7:0] cap [0:63];
    int ncap, first_cyc, err_seen, turn_err;
    logic first_busy, done_busy, got_done;

    // Reference CRC over bytes 0..n-1 (byte k has value k), bit-serial form.
    function automatic logic [7:0] crc_model(input int n);
        logic [7:0] c;
        logic [7:0] d;
        logic mix;
        c = 8'h00;
        for (int k = 0; k < n; k++) begin
            d = 8'(k);
            for (int b = 0; b < 8; b++) begin
                mix = c[0] ^ d[0];
                c = c >> 1;
                if (mix) c = c ^ 8'h8C;
                d = d >> 1;
            end
        end
        return c;
    endfunction

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            bus.send = 0; bus.buf_wr = 0; bus.tx_done = 0;
        end
    endtask

    task automatic write_buf(input logic [4:0] a, input logic [7:0] d);
        @(posedge clk); #1;
        bus.send = 0; bus.buf_wr = 1; bus.buf_addr = a; bus.buf_data = d;
    endtask

    task automatic start(input logic [7:0] len);
        @(posedge clk); #1;
        bus.buf_wr = 0; bus.send = 1; bus.send_len = len;
    endtask

    // Plays the UART: records strobes, answers each with tx_done after gap cycles.
    task automatic run_pkt(input int gap, input int inj_byte, input int stop_at, input int resend_len);
        int wr_cyc, dn_cyc;
        ncap = 0; got_done = 0; turn_err = 0; err_seen = 0;
        first_cyc = -1; first_busy = 0; done_busy = 1;
        wr_cyc = -100; dn_cyc = -100;
        for (int cyc = 0; cyc < 3000 && !got_done && !(stop_at > 0 && ncap >= stop_at); cyc++) begin
            @(posedge clk); #1;
            bus.tx_done = 0; bus.send = 0; bus.buf_wr = 0;
            if (bus.err) err_seen++;
            if (bus.tx_wr) begin
                if (ncap == 0) begin
                    first_cyc = cyc; first_busy = bus.busy;
                end else if (cyc != dn_cyc + 2) begin
                    turn_err++;
                end
                if (ncap < 64) cap[ncap] = bus.tx_data;
                ncap++;
                wr_cyc = cyc;
                if (ncap - 1 == inj_byte) begin
                    bus.send = 1; bus.send_len = 8'd1;
                    bus.buf_wr = 1; bus.buf_addr = 5'd0; bus.buf_data = 8'hEE;
                end
            end
            if (bus.done) begin
                got_done = 1; done_busy = bus.busy;
                if (cyc != dn_cyc + 2) turn_err++;
                if (resend_len >= 0) begin
                    bus.send = 1; bus.send_len = 8'(resend_len);
                end
            end
            if (!got_done && cyc == wr_cyc + gap) begin
                bus.tx_done = 1; dn_cyc = cyc;
            end
        end
    endtask

    task automatic check_pkt(input string name, input int exp_n, input logic [7:0] b0,
                             input logic [7:0] b1, input logic [7:0] b2, input logic [7:0] b3);
        logic [7:0] exp_b [0:3];
        exp_b[0] = b0; exp_b[1] = b1; exp_b[2] = b2; exp_b[3] = b3;
        checks++;
        if (ncap !== exp_n) begin
            errors++; $display("FAIL %s_count: got %0d want %0d", name, ncap, exp_n);
        end
        for (int i = 0; i < exp_n && i < 4; i++) begin
            checks++;
            if (cap[i] !== exp_b[i]) begin
                errors++; $display("FAIL %s_byte%0d: got %h want %h", name, i, cap[i], exp_b[i]);
            end
        end
        checks++;
        if (got_done !== 1'b1 || done_busy !== 1'b0) begin
            errors++; $display("FAIL %s_done: got done=%b busy=%b want done=1 busy=0", name, got_done, done_busy);
        end
        checks++;
        if (first_cyc !== 1 || first_busy !== 1'b1) begin
            errors++; $display("FAIL %s_start: got cycle %0d busy %b want cycle 1 busy 1", name, first_cyc, first_busy);
        end
        checks++;
        if (turn_err !== 0) begin
            errors++; $display("FAIL %s_turnaround: got %0d late strobes want 0", name, turn_err);
        end
    endtask

    task automatic test_reset();
        rst = 1;
        idle(2);
        checks++;
        if ({bus.busy, bus.done, bus.err, bus.tx_wr} !== 4'b0000) begin
            errors++; $display("FAIL reset_ctrl: got busy/done/err/wr=%b want 0000", {bus.busy, bus.done, bus.err, bus.tx_wr});
        end
        checks++;
        if (bus.tx_data !== 8'h00) begin
            errors++; $display("FAIL reset_data: got %h want 00", bus.tx_data);
        end
        @(posedge clk); #1;
        rst = 0;
        idle(1);
    endtask

    task automatic test_len0();
        start(8'd0);
        run_pkt(3, -1, 0, -1);
        check_pkt("len0", 3, 8'hD5, 8'h00, 8'h00, 8'h00);
    endtask

    task automatic test_single();
        write_buf(5'd0, 8'h01);
        start(8'd1);
        run_pkt(2, -1, 0, -1);
        check_pkt("one01", 4, 8'hD5, 8'h01, 8'h01, 8'h5E);
        write_buf(5'd0, 8'h00);
        start(8'd1);
        run_pkt(4, -1, 0, -1);
        check_pkt("one00", 4, 8'hD5, 8'h01, 8'h00, 8'h00);
    endtask

    task automatic test_full_and_back_to_back();
        logic [7:0] exp_crc;
        for (int i = 0; i < 32; i++) write_buf(5'(i), 8'(i));
        start(8'd32);
        run_pkt(3, -1, 0, 1);
        check_pkt("full", 35, 8'hD5, 8'h20, 8'h00, 8'h01);
        for (int i = 0; i < 32; i++) begin
            checks++;
            if (cap[2 + i] !== 8'(i)) begin
                errors++; $display("FAIL full_payload%0d: got %h want %h", i, cap[2 + i], 8'(i));
            end
        end
        exp_crc = crc_model(32);
        checks++;
        if (cap[34] !== exp_crc) begin
            errors++; $display("FAIL full_crc: got %h want %h", cap[34], exp_crc);
        end
        run_pkt(2, -1, 0, -1);
        check_pkt("b2b", 4, 8'hD5, 8'h01, 8'h00, 8'h00);
    endtask

    task automatic test_overlen();
        int wr_cnt, busy_cnt, err_cnt;
        wr_cnt = 0; busy_cnt = 0; err_cnt = 0;
        start(8'd33);
        @(posedge clk); #1;
        bus.send = 0;
        checks++;
        if (bus.err !== 1'b1) begin
            errors++; $display("FAIL overlen_err: got %b want 1", bus.err);
        end
        repeat (8) begin
            @(posedge clk); #1;
            if (bus.tx_wr) wr_cnt++;
            if (bus.busy) busy_cnt++;
            if (bus.err) err_cnt++;
        end
        checks++;
        if (wr_cnt !== 0 || busy_cnt !== 0 || err_cnt !== 0) begin
            errors++; $display("FAIL overlen_quiet: got wr=%0d busy=%0d err=%0d want 0 0 0", wr_cnt, busy_cnt, err_cnt);
        end
    endtask

    task automatic test_protect();
        int act;
        write_buf(5'd0, 8'h01);
        start(8'd1);
        run_pkt(3, 1, 0, -1);
        check_pkt("protect", 4, 8'hD5, 8'h01, 8'h01, 8'h5E);
        checks++;
        if (err_seen !== 0) begin
            errors++; $display("FAIL protect_err: got %0d err pulses want 0", err_seen);
        end
        act = 0;
        idle(1);
        bus.tx_done = 1;
        repeat (10) begin
            @(posedge clk); #1;
            bus.tx_done = 0;
            if (bus.tx_wr || bus.busy || bus.done || bus.err) act++;
        end
        checks++;
        if (act !== 0) begin
            errors++; $display("FAIL stray_done: got %0d active cycles want 0", act);
        end
        start(8'd1);
        run_pkt(3, -1, 0, -1);
        check_pkt("resend", 4, 8'hD5, 8'h01, 8'h01, 8'h5E);
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 8; i++) write_buf(5'(i), 8'(i));
        start(8'd8);
        run_pkt(3, -1, 5, -1);
        checks++;
        if (ncap !== 5 || cap[4] !== 8'h02) begin
            errors++; $display("FAIL midrst_pre: got %0d bytes last %h want 5 bytes last 02", ncap, cap[4]);
        end
        rst = 1;
        #1;
        checks++;
        if ({bus.busy, bus.done, bus.err, bus.tx_wr} !== 4'b0000 || bus.tx_data !== 8'h00) begin
            errors++; $display("FAIL midrst_out: got ctrl=%b data=%h want 0000 00",
                               {bus.busy, bus.done, bus.err, bus.tx_wr}, bus.tx_data);
        end
        @(posedge clk); #1;
        rst = 0;
        idle(2);
        start(8'd1);
        run_pkt(3, -1, 0, -1);
        check_pkt("postrst", 4, 8'hD5, 8'h01, 8'h00, 8'h00);
    endtask

    initial begin
        rst = 1;
        bus.buf_wr = 0; bus.buf_addr = '0; bus.buf_data = 8'h00;
        bus.send = 0; bus.send_len = 8'h00; bus.tx_done = 0;
        test_reset();
        test_len0();
        test_single();
        test_full_and_back_to_back();
        test_overlen();
        test_protect();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
